// File: rtl/core_inst_gen.sv
// rtl/core_inst_gen.sv - instruction sequencer driving the 48-bit core inst word for one conv layer
//
// Purpose: walks one convolution layer through weight staging, kernel load,
// activation staging, execute, OFIFO drain into psum SRAM and the final
// per-output accumulation, emitting one registered instruction word per cycle.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high
//   start        begin a layer (sampled in IDLE only)
//   ofifo_valid  OFIFO has data, from core
//   inst[47:0]   instruction word to core (registered)
//   busy         high from the cycle after start until done
//   done         one-cycle completion pulse
//
// Optional feature: define CORE_INST_GEN_DBI_EN to drive inst[47] high on
// every xmem read cycle; otherwise inst[47] is tied low.
module core_inst_gen #(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned len_kij = 9,
  parameter int unsigned k_w     = 3,
  parameter int unsigned in_w    = 6,
  parameter int unsigned out_w   = 4,
  parameter logic [10:0] w_base  = 11'd0,
  parameter logic [10:0] a_base  = 11'd1024,
  parameter logic [10:0] p_base  = 11'd0,
  parameter logic [10:0] f_base  = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [47:0] inst,
  output logic        busy,
  output logic        done
);

  localparam logic [47:0] IDLE_WORD = 48'h6001_800C_0000;
  localparam int unsigned NLEN = in_w * in_w;

  // Phase-length limits for the 16-bit step counter.
  localparam logic [15:0] C_COL      = 16'(col);
  localparam logic [15:0] C_COL_M1   = 16'(col - 1);
  localparam logic [15:0] C_FLUSH_M1 = 16'(row + col - 1);
  localparam logic [15:0] C_NLEN     = 16'(NLEN);
  localparam logic [15:0] C_NLEN_M1  = 16'(NLEN - 1);

  // Address-path constants; all address math is 11-bit and wraps.
  localparam logic [10:0] M_COL      = 11'(col);
  localparam logic [10:0] M_NLEN     = 11'(NLEN);
  localparam logic [10:0] M_INW      = 11'(in_w);
  localparam logic [10:0] M_KIJ_LAST = 11'(len_kij - 1);
  localparam logic [10:0] M_T_RD     = 11'(len_kij);
  localparam logic [10:0] M_T_LAST   = 11'(len_kij + 1);
  localparam logic [10:0] M_O_LAST   = 11'(out_w * out_w - 1);
  localparam logic [10:0] M_OC_LAST  = 11'(out_w - 1);
  localparam logic [10:0] M_KC_LAST  = 11'(k_w - 1);

  typedef enum logic [3:0] {
    IDLE, W_L0, W_LOAD, W_FLUSH, A_L0, EXEC, DRAIN, OF_RD, ACC
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt;                 // step within the current phase
  logic [10:0] kij;                 // kernel position being processed
  logic [10:0] o;                   // output index during ACC
  logic [10:0] t;                   // step within one output during ACC
  logic [10:0] o_r, o_c;            // o / out_w, o % out_w
  logic [10:0] k_r, k_c;            // t / k_w, t % k_w (valid for reads)
  logic        fin_last;            // final write of the layer is on inst
  logic [47:0] inst_next;

  // Instruction fields, assembled into inst_next.
  logic [1:0]  op;
  logic        l0_wr, l0_rd, ofifo_rd, acc, dbi;
  logic [10:0] xa, pa, fa;
  logic        xwen, xcen, pwen, pcen, fwen, fcen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = W_L0;
      W_L0:    if (cnt == C_COL) state_next = W_LOAD;
      W_LOAD:  if (cnt == C_COL_M1) state_next = W_FLUSH;
      W_FLUSH: if (cnt == C_FLUSH_M1) state_next = A_L0;
      A_L0:    if (cnt == C_NLEN) state_next = EXEC;
      EXEC:    if (cnt == C_NLEN_M1) state_next = DRAIN;
      DRAIN:   if (ofifo_valid) state_next = OF_RD;
      OF_RD:   if (cnt == C_NLEN) state_next = (kij == M_KIJ_LAST) ? ACC : W_L0;
      ACC:     if (t == M_T_LAST && o == M_O_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Phase counters. cnt restarts on every phase change; the ACC counters
  // are held at zero outside ACC so every entry starts at o=0, t=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      kij <= '0;
      o   <= '0;
      t   <= '0;
      o_r <= '0;
      o_c <= '0;
      k_r <= '0;
      k_c <= '0;
    end else begin
      if (state_next != state || state == IDLE || state == DRAIN) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end

      if (state == IDLE) begin
        kij <= '0;
      end else if (state == OF_RD && state_next == W_L0) begin
        kij <= kij + 11'd1;
      end

      if (state != ACC) begin
        o   <= '0;
        t   <= '0;
        o_r <= '0;
        o_c <= '0;
        k_r <= '0;
        k_c <= '0;
      end else if (t == M_T_LAST) begin
        t   <= '0;
        k_r <= '0;
        k_c <= '0;
        o   <= o + 11'd1;
        if (o_c == M_OC_LAST) begin
          o_c <= '0;
          o_r <= o_r + 11'd1;
        end else begin
          o_c <= o_c + 11'd1;
        end
      end else begin
        t <= t + 11'd1;
        if (k_c == M_KC_LAST) begin
          k_c <= '0;
          k_r <= k_r + 11'd1;
        end else begin
          k_c <= k_c + 11'd1;
        end
      end
    end
  end

  always_comb begin
    op       = 2'b00;
    l0_wr    = 1'b0;
    l0_rd    = 1'b0;
    ofifo_rd = 1'b0;
    acc      = 1'b0;
    xa       = '0;
    xwen     = 1'b1;
    xcen     = 1'b1;
    pa       = '0;
    pwen     = 1'b1;
    pcen     = 1'b1;
    fa       = '0;
    fwen     = 1'b1;
    fcen     = 1'b1;
    case (state)
      W_L0: begin
        // Read word i at step i; L0 captures it one step later.
        if (cnt < C_COL) begin
          xcen = 1'b0;
          xa   = w_base + kij * M_COL + cnt[10:0];
        end
        l0_wr = (cnt != 16'd0);
      end
      W_LOAD: begin
        l0_rd = 1'b1;
        op    = 2'b01;
      end
      A_L0: begin
        if (cnt < C_NLEN) begin
          xcen = 1'b0;
          xa   = a_base + cnt[10:0];
        end
        l0_wr = (cnt != 16'd0);
      end
      EXEC: begin
        l0_rd = 1'b1;
        op    = 2'b10;
      end
      OF_RD: begin
        // The psum write trails the OFIFO read by one step.
        ofifo_rd = (cnt < C_NLEN);
        if (cnt != 16'd0) begin
          pcen = 1'b0;
          pwen = 1'b0;
          pa   = p_base + kij * M_NLEN + cnt[10:0] - 11'd1;
        end
      end
      ACC: begin
        // Gather the len_kij partial sums that contribute to output o,
        // accumulate each one a step after its read, then store.
        if (t < M_T_RD) begin
          pcen = 1'b0;
          pa   = p_base + t * M_NLEN + (o_r + k_r) * M_INW + o_c + k_c;
        end
        acc = (t != 11'd0) && (t <= M_T_RD);
        if (t == M_T_LAST) begin
          fcen = 1'b0;
          fwen = 1'b0;
          fa   = f_base + o;
        end
      end
      default: begin
      end
    endcase
`ifdef CORE_INST_GEN_DBI_EN
    dbi = ~xcen;
`else
    dbi = 1'b0;
`endif
    inst_next = {dbi, fcen, fwen, fa, acc, pcen, pwen, pa, xcen, xwen, xa,
                 ofifo_rd, 2'b00, l0_rd, l0_wr, op};
  end

  // inst/busy follow the FSM by one cycle; done trails the final write.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst     <= IDLE_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
      fin_last <= 1'b0;
    end else begin
      inst     <= inst_next;
      busy     <= (state != IDLE);
      fin_last <= (state == ACC) && (t == M_T_LAST) && (o == M_O_LAST);
      done     <= fin_last;
    end
  end

endmodule
